pwm_mode_gen: RTL and testbench

Multi-channel, parametrised PWM generator with a key-selected operating mode.
- Debounced mode keys select one of NUM_MODES compare sets; all NUM_CH channels share one period counter.
- Compare values are double-buffered and take effect only at period boundaries, so outputs are glitch-free.
- Sits between the board keys/LEDs and the PWM pins; supersedes the fixed two-mode, single-output selector.

---
 rtl/pwm_pkg.sv | 33 +++
 rtl/key_debounce.sv | 58 +++++
 rtl/pwm_mode_gen.sv | 138 +++++++++++++
 tb/tb_pwm_mode_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the key-selected PWM generator.
package pwm_pkg;

    // Upper bound on mode keys handled by the one-hot decoder.
    localparam int unsigned MAX_MODES = 32;
    localparam int unsigned IDX_W     = 5;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } onehot_t;

    // Width of a mode index, never less than one bit.
    function automatic int unsigned mode_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic popcount_is_one(input logic [MAX_MODES-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_MODES'(1))) == '0);
    endfunction

    // Returns {valid, index}; valid only when exactly one bit is set.
    function automatic onehot_t onehot_idx(input logic [MAX_MODES-1:0] vec);
        onehot_t r;
        r.valid = popcount_is_one(vec);
        r.idx   = '0;
        for (int unsigned i = 0; i < MAX_MODES; i++) begin
            if (vec[i]) r.idx = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser and debouncer: strobes once per newly stable pattern.
module key_debounce #(
    parameter int unsigned W          = 2,
    parameter int unsigned DEB_CYC    = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key_i,
    output logic         acc_stb_o,
    output logic [W-1:0] acc_pat_o
);

    localparam int unsigned CW = $clog2(DEB_CYC + 1);

    logic [W-1:0]  sync1_q, sync2_q;
    logic [W-1:0]  prev_q, prev_d;
    logic [W-1:0]  pat;
    logic [CW-1:0] cnt_q, cnt_d, hit;
    logic          armed_q, armed_d, armed_eff, acc;

    // Pattern after synchronisation, 1 = pressed.
    assign pat = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Count consecutive identical cycles (saturating); accept once per new pattern.
    always_comb begin
        hit       = CW'(1);
        armed_eff = armed_q | (pat != prev_q);
        if (pat == prev_q) begin
            hit = (cnt_q == CW'(DEB_CYC)) ? cnt_q : cnt_q + CW'(1);
        end
        acc     = armed_eff && (hit == CW'(DEB_CYC));
        prev_d  = pat;
        cnt_d   = hit;
        armed_d = armed_eff & ~acc;
    end

    // Synchroniser and stability state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign acc_stb_o = acc;
    assign acc_pat_o = pat;

endmodule

// File: rtl/pwm_mode_gen.sv
// Multi-channel PWM generator with debounced key-selected compare sets.
module pwm_mode_gen
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned PERIOD         = 626,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned NUM_MODES      = 2,
    parameter int unsigned DEB_CYC        = 50000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MODES-1:0]              key,
    input  logic [NUM_MODES*NUM_CH*CNT_W-1:0] cmp_tab,
    output logic [NUM_MODES-1:0]              led,
    output logic [NUM_CH-1:0]                 pwm,
    output logic                              period_done
);

    localparam int unsigned       MODE_W = mode_w(NUM_MODES);
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(PERIOD - 1);

    if (PERIOD < 2 || longint'(PERIOD) > (longint'(1) << CNT_W)) begin : g_bad_period
        $error("PERIOD must be in 2..2**CNT_W");
    end
    if (NUM_MODES > MAX_MODES) begin : g_bad_modes
        $error("NUM_MODES exceeds MAX_MODES");
    end

    logic                 acc_stb;
    logic [NUM_MODES-1:0] acc_pat;
    onehot_t              oh;
    logic                 req;
    logic [MODE_W-1:0]    req_mode;

    logic [CNT_W-1:0]     tab [NUM_MODES][NUM_CH];

    logic                 mode_valid_q, mode_valid_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic                 pending_q, pending_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     shadow_q [NUM_CH];
    logic [CNT_W-1:0]     shadow_d [NUM_CH];
    logic [NUM_CH-1:0]    pwm_q, pwm_d;
    logic                 pd_q, pd_d;
    logic [NUM_MODES-1:0] led_q, led_d;

    key_debounce #(
        .W          (NUM_MODES),
        .DEB_CYC    (DEB_CYC),
        .ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .key_i     (key),
        .acc_stb_o (acc_stb),
        .acc_pat_o (acc_pat)
    );

    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign tab[m][c] = cmp_tab[(m*NUM_CH+c)*CNT_W +: CNT_W];
        end
    end

    assign oh       = onehot_idx(MAX_MODES'(acc_pat));
    assign req      = acc_stb & oh.valid;
    assign req_mode = MODE_W'(oh.idx);

    // Mode selection, period counter, boundary shadow reload and compare.
    always_comb begin
        mode_valid_d = mode_valid_q;
        mode_d       = mode_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        if (!mode_valid_q) begin
            cnt_d = '0;
            if (req) begin
                mode_valid_d = 1'b1;
                mode_d       = req_mode;
                for (int unsigned c = 0; c < NUM_CH; c++) shadow_d[c] = tab[req_mode][c];
            end
        end else begin
            if (req && req_mode != mode_q) begin
                mode_d    = req_mode;
                pending_d = 1'b1;
            end
            // A request in the boundary cycle already steers this reload via mode_d.
            if (cnt_q == LAST) begin
                cnt_d     = '0;
                pending_d = 1'b0;
                for (int unsigned c = 0; c < NUM_CH; c++) shadow_d[c] = tab[mode_d][c];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        pd_d = mode_valid_d && (cnt_d == LAST);
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            pwm_d[c] = mode_valid_q && (cnt_q >= shadow_q[c]);
        end
        led_d = mode_valid_d ? (NUM_MODES'(1) << mode_d) : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_valid_q <= 1'b0;
            mode_q       <= '0;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            shadow_q     <= '{default: '0};
            pwm_q        <= '0;
            pd_q         <= 1'b0;
            led_q        <= '0;
        end else begin
            mode_valid_q <= mode_valid_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            pwm_q        <= pwm_d;
            pd_q         <= pd_d;
            led_q        <= led_d;
        end
    end

    // A pending switch can only exist while a mode is active.
    always_ff @(posedge clk) begin
        if (!rst) assert (!pending_q || mode_valid_q);
    end

    assign led         = led_q;
    assign pwm         = pwm_q;
    assign period_done = pd_q;

endmodule

// File: tb/tb_pwm_mode_gen.sv
// Randomised self-checking bench for pwm_mode_gen against a per-period model.
module tb_pwm_mode_gen;

    localparam int CNT_W     = 16;
    localparam int PERIOD    = 626;
    localparam int NUM_CH    = 2;
    localparam int NUM_MODES = 2;
    localparam int DEB_CYC   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_MODES-1:0] key = '1;
    logic [NUM_MODES*NUM_CH*CNT_W-1:0] cmp_tab = '0;
    logic [NUM_MODES-1:0] led;
    logic [NUM_CH-1:0] pwm;
    logic period_done;

    int tab [NUM_MODES][NUM_CH];
    int shadow_m [NUM_CH];
    int model_mode = 0;
    bit model_valid = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_mode_gen #(
        .CNT_W          (CNT_W),
        .PERIOD         (PERIOD),
        .NUM_CH         (NUM_CH),
        .NUM_MODES      (NUM_MODES),
        .DEB_CYC        (DEB_CYC),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .cmp_tab     (cmp_tab),
        .led         (led),
        .pwm         (pwm),
        .period_done (period_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tab();
        for (int m = 0; m < NUM_MODES; m++)
            for (int c = 0; c < NUM_CH; c++)
                cmp_tab[(m*NUM_CH+c)*CNT_W +: CNT_W] = CNT_W'(tab[m][c]);
    endtask

    function automatic int exp_hi(input int s);
        return (s >= PERIOD) ? 0 : PERIOD - s;
    endfunction

    function automatic int exp_rise(input int s);
        return (s > 0 && s < PERIOD) ? 1 : 0;
    endfunction

    function automatic logic [NUM_MODES-1:0] exp_led();
        return model_valid ? (NUM_MODES'(1) << model_mode) : '0;
    endfunction

    function automatic logic [NUM_MODES-1:0] key_for(input int m);
        return ~(NUM_MODES'(1) << m);
    endfunction

    // Wait for a boundary; the compare in force for the next period is cmp_tab[mode] now.
    task automatic wait_pd();
        int n = 0;
        while (period_done !== 1'b1 && n < 2*PERIOD) begin
            tick();
            n++;
        end
        if (period_done !== 1'b1) chk("pd_timeout", 0, 1);
        for (int c = 0; c < NUM_CH; c++) shadow_m[c] = tab[model_mode][c];
    endtask

    // Observe one full period of pwm, optionally pressing a key or editing cmp_tab inside it.
    task automatic measure(input int press_at, input int press_mode,
                           input int edit_at, input int em, input int ec, input int ev);
        int hi [NUM_CH];
        int rises [NUM_CH];
        int pds = 0;
        int pd_idx = -1;
        logic [NUM_CH-1:0] prev;
        wait_pd();
        tick();
        for (int c = 0; c < NUM_CH; c++) begin hi[c] = 0; rises[c] = 0; end
        prev = pwm;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                hi[c] += int'(pwm[c]);
                if (i > 0 && pwm[c] && !prev[c]) rises[c]++;
            end
            if (period_done) begin pds++; pd_idx = i; end
            prev = pwm;
            if (i == press_at) key = key_for(press_mode);
            if (i == press_at + 8) begin
                model_mode = press_mode;
                chk("led_switch", 32'(led), 32'(exp_led()));
            end
            if (i == press_at + 10) key = '1;
            if (i == edit_at) begin
                tab[em][ec] = ev;
                push_tab();
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("high_ch%0d_s%0d", c, shadow_m[c]), 32'(hi[c]), 32'(exp_hi(shadow_m[c])));
            chk($sformatf("rise_ch%0d_s%0d", c, shadow_m[c]), 32'(rises[c]), 32'(exp_rise(shadow_m[c])));
        end
        chk("pd_per_period", 32'(pds), 32'd1);
        chk("pd_position", 32'(pd_idx), 32'(PERIOD - 2));
        chk("led_hold", 32'(led), 32'(exp_led()));
    endtask

    // Press a single key from idle and confirm the exact acceptance latency.
    task automatic press_from_idle(input int m);
        key = key_for(m);
        repeat (5) tick();
        chk("led_before_accept", 32'(led), 32'(exp_led()));
        tick();
        model_mode = m;
        model_valid = 1'b1;
        chk("led_accept", 32'(led), 32'(exp_led()));
        repeat (4) tick();
        key = '1;
    endtask

    task automatic idle_check(input int cycles, input string tag);
        int bad_pwm = 0;
        int bad_led = 0;
        int n_pd = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (pwm !== '0) bad_pwm++;
            if (led !== '0) bad_led++;
            if (period_done !== 1'b0) n_pd++;
        end
        chk({tag, "_pwm"}, 32'(bad_pwm), 32'd0);
        chk({tag, "_led"}, 32'(bad_led), 32'd0);
        chk({tag, "_pd"}, 32'(n_pd), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, c, v, pa;
        tab[0][0] = 200; tab[0][1] = 400;
        tab[1][0] = 100; tab[1][1] = 626;
        push_tab();

        // Reset and idle keys.
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_pwm", 32'(pwm), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_pd", 32'(period_done), 32'd0);
        idle_check(2000, "idle");

        // Enter mode 0 and observe steady periods.
        press_from_idle(0);
        measure(-100, 0, -1, 0, 0, 0);
        measure(-100, 0, -1, 0, 0, 0);

        // Switch to mode 1 mid-period; takes effect at the boundary.
        measure(300, 1, -1, 0, 0, 0);
        measure(-100, 0, -1, 0, 0, 0);

        // Both keys, then a short bounce showing key0 alone: no mode change.
        key = 2'b00;
        repeat (10) tick();
        key = 2'b10;
        repeat (2) tick();
        key = 2'b00;
        repeat (10) tick();
        key = 2'b11;
        repeat (10) tick();
        chk("bounce_both_led", 32'(led), 32'(exp_led()));
        key = 2'b10;
        repeat (2) tick();
        key = 2'b11;
        repeat (12) tick();
        chk("bounce_single_led", 32'(led), 32'(exp_led()));
        measure(-100, 0, -1, 0, 0, 0);

        // Edit mode1 ch0 to 0 mid-period: constant high from the next period.
        measure(-100, 0, 250, 1, 0, 0);
        measure(-100, 0, -1, 0, 0, 0);

        // Randomised edits and mode presses.
        for (int it = 0; it < 6; it++) begin
            m = int'($urandom_range(0, NUM_MODES - 1));
            c = int'($urandom_range(0, NUM_CH - 1));
            case ($urandom_range(0, 3))
                0: v = 0;
                1: v = int'($urandom_range(1, PERIOD - 1));
                2: v = int'($urandom_range(PERIOD, PERIOD + 100));
                default: v = 65535;
            endcase
            pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, PERIOD - 30)) : -100;
            measure(pa, int'($urandom_range(0, NUM_MODES - 1)),
                    int'($urandom_range(0, PERIOD - 10)), m, c, v);
            measure(-100, 0, -1, 0, 0, 0);
        end

        // Reset mid-period at cnt=350.
        wait_pd();
        repeat (351) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_valid = 1'b0;
        chk("midrst_pwm", 32'(pwm), 32'd0);
        chk("midrst_led", 32'(led), 32'd0);
        chk("midrst_pd", 32'(period_done), 32'd0);
        idle_check(700, "post_rst");

        // A fresh press restarts generation.
        press_from_idle(1);
        measure(-100, 0, -1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
